// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider; new divisors wait in a shadow register until a period boundary.
// Optional feature macro CLK_DIV_SYNC_EN: sync_in forces a boundary on every channel at once.
module clk_div_prog #(
   parameter int unsigned NCH     = 2,
   parameter int unsigned WIDTH   = 27,
   parameter int unsigned DEF_DIV = 2
) (
   input  logic                 clk,
   input  logic                 rst_in,
   input  logic [NCH*WIDTH-1:0] div_f,
   input  logic [NCH-1:0]       load,
   input  logic                 sync_in,
   output logic [NCH-1:0]       div_clk,
   output logic [NCH-1:0]       tick,
   output logic [NCH-1:0]       pending
);

   localparam logic [WIDTH-1:0] DEF = WIDTH'(DEF_DIV);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] shadow_q [NCH];
   logic [WIDTH-1:0] shadow_d [NCH];
   logic [WIDTH-1:0] div_q    [NCH];
   logic [WIDTH-1:0] div_d    [NCH];
   logic [WIDTH-1:0] cnt_q    [NCH];
   logic [WIDTH-1:0] cnt_d    [NCH];
   logic [NCH-1:0]   pending_d;
   logic [NCH-1:0]   div_clk_d;
   logic [NCH-1:0]   tick_d;
   logic [NCH-1:0]   boundary;
   logic             run_q;   // low until the first edge after reset, which opens the first period
   logic             sync_hit;

`ifdef CLK_DIV_SYNC_EN
   assign sync_hit = sync_in;
`else
   logic unused_sync;
   assign unused_sync = sync_in;
   assign sync_hit    = 1'b0;
`endif

   function automatic logic is_active(input logic [WIDTH-1:0] d);
      return d > ONE;
   endfunction

   // ceil(d/2) without forming d+1, so the all-ones divisor cannot overflow
   function automatic logic [WIDTH-1:0] half_up(input logic [WIDTH-1:0] d);
      return (d >> 1) + WIDTH'(d[0]);
   endfunction

   always_comb begin
      // NOTE: every target gets a default before any decision, so no latch can be inferred.
      shadow_d  = shadow_q;
      div_d     = div_q;
      pending_d = pending;
      div_clk_d = '0;
      tick_d    = '0;
      boundary  = '0;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i]    = cnt_q[i] + ONE;
         boundary[i] = !run_q || sync_hit || !is_active(div_q[i]) || (cnt_q[i] == div_q[i] - ONE);
         if (boundary[i]) begin
            cnt_d[i]     = '0;
            pending_d[i] = 1'b0;
            if (load[i]) begin
               shadow_d[i] = div_f[i*WIDTH +: WIDTH];
               div_d[i]    = div_f[i*WIDTH +: WIDTH];
            end else if (pending[i]) begin
               div_d[i] = shadow_q[i];
            end
         end else if (load[i]) begin
            shadow_d[i]  = div_f[i*WIDTH +: WIDTH];
            pending_d[i] = 1'b1;
         end
         if (!is_active(div_d[i])) begin
            cnt_d[i] = '0;
         end
         tick_d[i]    = is_active(div_d[i]) && (cnt_d[i] == '0);
         div_clk_d[i] = is_active(div_d[i]) && (cnt_d[i] < half_up(div_d[i]));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_in) begin
         // NOTE: these arrays are ordinary flops rather than RAM, so resetting them is legal and drops stale shadows.
         run_q   <= 1'b0;
         pending <= '0;
         div_clk <= '0;
         tick    <= '0;
         for (int i = 0; i < NCH; i++) begin
            shadow_q[i] <= DEF;
            div_q[i]    <= DEF;
            cnt_q[i]    <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         run_q    <= 1'b1;
         pending  <= pending_d;
         div_clk  <= div_clk_d;
         tick     <= tick_d;
         shadow_q <= shadow_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios then random loads/sync/reset against a
// period-start-time reference model.
module tb_clk_div_prog;

   localparam int NCH = 3;
   localparam int W   = 5;
   localparam int DEF = 2;

   logic           clk = 1'b0;
   logic           rst_in;
   logic [NCH*W-1:0] div_f;
   logic [NCH-1:0] load;
   logic           sync_in;
   logic [NCH-1:0] div_clk;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] pending;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model: divisor, shadow, pending flag, and the edge index at which the current period began
   int unsigned m_div    [NCH];
   int unsigned m_shadow [NCH];
   bit          m_pend   [NCH];
   longint      m_start  [NCH];
   bit          m_rst   = 1'b1;
   bit          m_first = 1'b1;
   longint      cyc     = 0;

   clk_div_prog #(.NCH(NCH), .WIDTH(W), .DEF_DIV(DEF)) dut (
      .clk     (clk),
      .rst_in  (rst_in),
      .div_f   (div_f),
      .load    (load),
      .sync_in (sync_in),
      .div_clk (div_clk),
      .tick    (tick),
      .pending (pending)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit sync_eff;
      cyc++;
`ifdef CLK_DIV_SYNC_EN
      sync_eff = sync_in;
`else
      sync_eff = 1'b0;
`endif
      if (!rst_in) begin
         m_rst   = 1'b1;
         m_first = 1'b1;
         for (int ch = 0; ch < NCH; ch++) begin
            m_div[ch]    = DEF;
            m_shadow[ch] = DEF;
            m_pend[ch]   = 1'b0;
            m_start[ch]  = cyc;
         end
         return;
      end
      m_rst = 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
         int unsigned sl;
         bit bnd;
         sl  = div_f[ch*W +: W];
         bnd = m_first || sync_eff || (m_div[ch] < 2) || ((cyc - m_start[ch]) == longint'(m_div[ch]));
         if (bnd) begin
            if (load[ch]) begin
               m_div[ch]    = sl;
               m_shadow[ch] = sl;
            end else if (m_pend[ch]) begin
               m_div[ch] = m_shadow[ch];
            end
            m_pend[ch]  = 1'b0;
            m_start[ch] = cyc;
         end else if (load[ch]) begin
            m_shadow[ch] = sl;
            m_pend[ch]   = 1'b1;
         end
      end
      m_first = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      logic [NCH-1:0] e_clk, e_tick, e_pend;
      for (int ch = 0; ch < NCH; ch++) begin
         longint ph;
         bit act;
         ph  = cyc - m_start[ch];
         act = !m_rst && (m_div[ch] >= 2);
         e_tick[ch] = act && (ph == 0);
         e_clk[ch]  = act && (2 * ph < longint'(m_div[ch]));
         e_pend[ch] = !m_rst && m_pend[ch];
      end
      chk({tag, "/div_clk"}, div_clk, e_clk);
      chk({tag, "/tick"}, tick, e_tick);
      chk({tag, "/pending"}, pending, e_pend);
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_outputs(tag);
   endtask

   task automatic do_load(input int ch, input int val, input string tag);
      div_f[ch*W +: W] = W'(val);
      load[ch] = 1'b1;
      cycle(tag);
      load = '0;
   endtask

   task automatic wait_phase(input int ch, input longint ph);
      bit hit = 1'b0;
      for (int k = 0; k < 64 && !hit; k++) begin
         if (!m_rst && m_div[ch] >= 2 && (cyc - m_start[ch]) == ph) hit = 1'b1;
         else cycle("wait");
      end
      n_assert++;
      assert (hit) else begin
         n_fail++;
         $error("FAIL wait_phase ch%0d observed=timeout expected=phase %0d", ch, ph);
      end
   endtask

   initial begin
      rst_in  = 1'b0;
      load    = '0;
      div_f   = '0;
      sync_in = 1'b0;

      repeat (3) cycle("reset");
      rst_in = 1'b1;
      cycle("release");
      chk("first_tick", tick, '1);
      chk("first_div_clk", div_clk, '1);
      repeat (6) cycle("def_div");

      // divisor 5 on channel 0: waits for the current period, then 3 high / 2 low
      do_load(0, 5, "load5");
      chk("pend_after_load5", NCH'(pending[0]), NCH'(1));
      repeat (15) cycle("div5");

      // channel 1: period 4, then 6 loaded mid-period, then 7 loaded on a boundary
      do_load(1, 4, "load4");
      repeat (6) cycle("div4");
      wait_phase(1, 1);
      do_load(1, 6, "load6_mid");
      repeat (14) cycle("div6");
      wait_phase(1, 5);
      do_load(1, 7, "load7_bnd");
      chk("pend_bnd_load", NCH'(pending[1]), NCH'(0));
      repeat (10) cycle("div7");

      // repeated loads before the boundary: only the last one lands
      wait_phase(1, 0);
      do_load(1, 9, "load9");
      do_load(1, 4, "load4_over");
      repeat (14) cycle("overwrite");

      // channel 2: disable with 0, then re-enable with 3
      do_load(2, 0, "load0");
      repeat (10) cycle("inactive");
      chk("inactive_tick", NCH'(tick[2]), NCH'(0));
      do_load(2, 3, "load3");
      chk("restart_tick", NCH'(tick[2]), NCH'(1));
      repeat (8) cycle("div3");

      // all-ones divisor
      do_load(2, 31, "load31");
      repeat (70) cycle("div31");

      // sync pulse with ch0 = 3, ch1 = 4
      do_load(0, 3, "sync_setup0");
      do_load(1, 4, "sync_setup1");
      repeat (12) cycle("pre_sync");
      sync_in = 1'b1;
      cycle("sync");
      sync_in = 1'b0;
`ifdef CLK_DIV_SYNC_EN
      chk("sync_align", tick & NCH'(3), NCH'(3));
`endif
      repeat (25) cycle("post_sync");

      // reset while ch1 holds a pending 9
      wait_phase(1, 0);
      do_load(1, 9, "pend9");
      chk("pend9_set", NCH'(pending[1]), NCH'(1));
      rst_in = 1'b0;
      cycle("mid_reset");
      chk("mid_reset_outputs", div_clk | tick | pending, '0);
      rst_in = 1'b1;
      repeat (10) cycle("after_reset");
      chk("after_reset_pend", pending, '0);

      // randomized loads, sync pulses and occasional reset
      for (int n = 0; n < 600; n++) begin
         load    = NCH'($urandom_range(0, 7) == 0 ? $urandom : 0);
         div_f   = (NCH*W)'($urandom);
         sync_in = ($urandom_range(0, 19) == 0);
         rst_in  = ($urandom_range(0, 149) != 0);
         cycle("random");
      end
      load    = '0;
      sync_in = 1'b0;
      rst_in  = 1'b1;
      repeat (5) cycle("drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
